// File: rtl/alu_pkg.sv
// Shared types and constants for the 74181-style ALU and its command sequencer.
package alu_pkg;

  localparam int unsigned ALU_W = 16;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Control fields of a command, latched at accept.
  typedef struct packed {
    logic       mode;
    logic [3:0] select;
    logic       cin;
    logic       wide;
  } cmd_ctl_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-drive signals of the sequencer, grouped for port hookup.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_W
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_mode;
  logic [3:0]           cmd_select;
  logic                 cmd_cin;
  logic                 cmd_wide;
  logic [2*WIDTH-1:0]   cmd_a;
  logic [2*WIDTH-1:0]   cmd_b;

  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [3:0]           alu_select;
  logic                 alu_mode;
  logic                 alu_carry_in;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_carry_out;
  logic                 alu_compare;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_data;
  logic                 rsp_carry;
  logic                 rsp_equal;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_mode, cmd_select, cmd_cin, cmd_wide, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_select, alu_mode, alu_carry_in,
    input  alu_out, alu_carry_out, alu_compare,
    output rsp_valid, rsp_data, rsp_carry, rsp_equal,
    input  rsp_ready
  );

  // Environment side: issues commands, consumes responses, hosts the ALU.
  modport master (
    output cmd_valid, cmd_mode, cmd_select, cmd_cin, cmd_wide, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_select, alu_mode, alu_carry_in,
    output alu_out, alu_carry_out, alu_compare,
    input  rsp_valid, rsp_data, rsp_carry, rsp_equal,
    output rsp_ready
  );

endinterface

// File: rtl/alu74181.sv
// Combinational WIDTH-bit 74181-style ALU (active-high data, carry_in=1 adds one).
module alu74181
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             carry_in,
  output logic [WIDTH-1:0] f,
  output logic             carry_out,
  output logic             compare
);

  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] y_c;
  logic [WIDTH:0]   sum_c;

  // Select bits gate B/~B into the propagate (x) and generate (y) terms.
  always_comb begin
    x_c   = a | (select[0] ? b : '0) | (select[1] ? ~b : '0);
    y_c   = (select[2] ? (a & ~b) : '0) | (select[3] ? (a & b) : '0);
    sum_c = {1'b0, x_c} + {1'b0, y_c} + (WIDTH+1)'(carry_in);
  end

  assign f         = (mode == MODE_LOGIC) ? ~(x_c ^ y_c) : sum_c[WIDTH-1:0];
  assign carry_out = (mode == MODE_LOGIC) ? 1'b0 : sum_c[WIDTH];
  assign compare   = (a == b);

endmodule

// File: rtl/alu_sequencer.sv
// Drives a WIDTH-bit ALU from valid/ready commands; wide commands run two chained passes.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave bus
);

  localparam int unsigned DW = 2 * WIDTH;

  seq_state_t       state_q;
  seq_state_t       state_d;
  cmd_ctl_t         ctl_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [DW-1:0]    result_q;
  logic             carry_q;
  logic             eq_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             accept_c;

  logic [WIDTH-1:0] alu_a_c;
  logic [WIDTH-1:0] alu_b_c;
  logic [3:0]       alu_select_c;
  logic             alu_mode_c;
  logic             alu_carry_in_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and ALU drive; idle values unless a pass is running.
  always_comb begin
    state_d        = state_q;
    accept_c       = 1'b0;
    alu_a_c        = '0;
    alu_b_c        = '0;
    alu_select_c   = 4'd0;
    alu_mode_c     = MODE_LOGIC;
    alu_carry_in_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          accept_c = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        alu_a_c        = a_q[WIDTH-1:0];
        alu_b_c        = b_q[WIDTH-1:0];
        alu_select_c   = ctl_q.select;
        alu_mode_c     = ctl_q.mode;
        alu_carry_in_c = ctl_q.cin;
        state_d        = ctl_q.wide ? HIGH : DONE;
      end
      HIGH: begin
        alu_a_c        = a_q[DW-1:WIDTH];
        alu_b_c        = b_q[DW-1:WIDTH];
        alu_select_c   = ctl_q.select;
        alu_mode_c     = ctl_q.mode;
        // Logic mode has no carry chain, so the command carry is reused.
        alu_carry_in_c = (ctl_q.mode == MODE_ARITH) ? carry_q : ctl_q.cin;
        state_d        = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, pass captures and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        ctl_q.mode   <= bus.cmd_mode;
        ctl_q.select <= bus.cmd_select;
        ctl_q.cin    <= bus.cmd_cin;
        ctl_q.wide   <= bus.cmd_wide;
        a_q          <= bus.cmd_a;
        b_q          <= bus.cmd_b;
      end
      if (state_q == LOW) begin
        result_q <= {WIDTH'(0), bus.alu_out};
        carry_q  <= bus.alu_carry_out;
        eq_q     <= bus.alu_compare;
      end else if (state_q == HIGH) begin
        result_q[DW-1:WIDTH] <= bus.alu_out;
        carry_q              <= bus.alu_carry_out;
        eq_q                 <= eq_q & bus.alu_compare;
      end
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == DONE);
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = result_q;
  assign bus.rsp_carry    = carry_q;
  assign bus.rsp_equal    = eq_q;
  assign bus.alu_a        = alu_a_c;
  assign bus.alu_b        = alu_b_c;
  assign bus.alu_select   = alu_select_c;
  assign bus.alu_mode     = alu_mode_c;
  assign bus.alu_carry_in = alu_carry_in_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer + alu74181: directed cases, random commands, backpressure and mid-op reset.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic last_hi_cin;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16)) bus ();

  alu_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu74181 #(.WIDTH(16)) u_alu (
    .a         (bus.alu_a),
    .b         (bus.alu_b),
    .select    (bus.alu_select),
    .mode      (bus.alu_mode),
    .carry_in  (bus.alu_carry_in),
    .f         (bus.alu_out),
    .carry_out (bus.alu_carry_out),
    .compare   (bus.alu_compare)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Datasheet function table evaluated over the whole active width at once.
  function automatic void ref_model(input logic mode, input logic [3:0] sel, input logic cin,
                                    input logic wide, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output logic c, output logic e);
    int unsigned w;
    logic [63:0] mask, aa, bb, nb, ones, r;
    w    = wide ? 32 : 16;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    nb   = ~bb & mask;
    ones = mask;
    r    = '0;
    if (mode) begin
      case (sel)
        4'd0:  r = ~aa;
        4'd1:  r = ~(aa | bb);
        4'd2:  r = ~aa & bb;
        4'd3:  r = 64'd0;
        4'd4:  r = ~(aa & bb);
        4'd5:  r = ~bb;
        4'd6:  r = aa ^ bb;
        4'd7:  r = aa & nb;
        4'd8:  r = ~aa | bb;
        4'd9:  r = ~(aa ^ bb);
        4'd10: r = bb;
        4'd11: r = aa & bb;
        4'd12: r = ones;
        4'd13: r = aa | nb;
        4'd14: r = aa | bb;
        default: r = aa;
      endcase
      c = 1'b0;
    end else begin
      case (sel)
        4'd0:  r = aa;
        4'd1:  r = aa | bb;
        4'd2:  r = aa | nb;
        4'd3:  r = ones;
        4'd4:  r = aa + (aa & nb);
        4'd5:  r = (aa | bb) + (aa & nb);
        4'd6:  r = aa + nb;
        4'd7:  r = (aa & nb) + ones;
        4'd8:  r = aa + (aa & bb);
        4'd9:  r = aa + bb;
        4'd10: r = (aa | nb) + (aa & bb);
        4'd11: r = (aa & bb) + ones;
        4'd12: r = aa + aa;
        4'd13: r = (aa | bb) + aa;
        4'd14: r = (aa | nb) + aa;
        default: r = aa + ones;
      endcase
      r = r + {63'd0, cin};
      c = r[w];
    end
    r = r & mask;
    d = r[31:0];
    e = (aa == bb);
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input logic mode, input logic [3:0] sel, input logic cin, input logic wide,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         input bit keep_valid);
    logic [31:0] ed;
    logic        ec, ee;
    int          n;
    bit          ok;
    ref_model(mode, sel, cin, wide, a, b, ed, ec, ee);
    @(negedge clk);
    bus.cmd_mode   = mode;
    bus.cmd_select = sel;
    bus.cmd_cin    = cin;
    bus.cmd_wide   = wide;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_valid  = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      check("accept_timeout", 64'(0), 64'(1));
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (keep_valid) begin
      bus.cmd_mode   = 1'($urandom);
      bus.cmd_select = 4'($urandom);
      bus.cmd_cin    = 1'($urandom);
      bus.cmd_wide   = 1'($urandom);
      bus.cmd_a      = $urandom;
      bus.cmd_b      = $urandom;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    check("busy_ready", 64'(bus.cmd_ready), 64'(0));
    n = 1;
    last_hi_cin = 1'b0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 2 && wide) last_hi_cin = bus.alu_carry_in;
    end
    check("latency", 64'(n), 64'(wide ? 3 : 2));
    check("rsp_data", 64'(bus.rsp_data), 64'(ed));
    check("rsp_carry", 64'(bus.rsp_carry), 64'(ec));
    check("rsp_equal", 64'(bus.rsp_equal), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'(1));
      check("hold_ready", 64'(bus.cmd_ready), 64'(0));
      check("hold_data", {31'd0, bus.rsp_carry, bus.rsp_equal, bus.rsp_data}, {31'd0, ec, ee, ed});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("rsp_drop", 64'(bus.rsp_valid), 64'(0));
    check("ready_back", 64'(bus.cmd_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int          pick;
    bit          ok;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 1'b0;
    bus.cmd_select = 4'd0;
    bus.cmd_cin    = 1'b0;
    bus.cmd_wide   = 1'b0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_bits", {31'd0, bus.rsp_carry, bus.rsp_equal, bus.rsp_data}, 64'd0);
    check("rst_alu_idle", {43'd0, bus.alu_mode, bus.alu_carry_in, bus.alu_select, bus.alu_a},
          {43'd0, 1'b1, 1'b0, 4'd0, 16'd0});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Narrow and wide add of 0xFFFF + 1.
    run_cmd(MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 0, 1'b0);
    run_cmd(MODE_ARITH, SEL_ADD, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 0, 1'b0);
    check("high_cin", 64'(last_hi_cin), 64'(1));
    run_cmd(MODE_LOGIC, SEL_XOR, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 1'b0);
    run_cmd(MODE_ARITH, SEL_ADD, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 0, 1'b0);
    run_cmd(MODE_ARITH, SEL_ADD, 1'b0, 1'b1, 32'h1235_5678, 32'h1234_5678, 0, 1'b0);
    // Backpressure with a competing command held on the bus.
    run_cmd(MODE_ARITH, 4'b0110, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_0002, 5, 1'b1);

    for (int k = 0; k < 40; k++) begin
      ra   = $urandom;
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      rb = ra;
      else if (pick == 1) rb = ra ^ 32'h0001_0000;
      else                rb = $urandom;
      run_cmd(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), ra, rb,
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Leave a nonzero response behind, then reset in the middle of a wide pass.
    run_cmd(MODE_LOGIC, SEL_XOR, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 1'b0);
    @(negedge clk);
    bus.cmd_mode   = MODE_ARITH;
    bus.cmd_select = SEL_ADD;
    bus.cmd_cin    = 1'b1;
    bus.cmd_wide   = 1'b1;
    bus.cmd_a      = 32'hABCD_1234;
    bus.cmd_b      = 32'h1111_FFFF;
    bus.cmd_valid  = 1'b1;
    wait_ready(ok);
    if (!ok) check("rst_accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("high_alu_a", 64'(bus.alu_a), 64'(16'hABCD));
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("abort_rsp_bits", {31'd0, bus.rsp_carry, bus.rsp_equal, bus.rsp_data}, 64'd0);
    check("abort_alu_idle", {43'd0, bus.alu_mode, bus.alu_carry_in, bus.alu_select, bus.alu_a},
          {43'd0, 1'b1, 1'b0, 4'd0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    run_cmd(MODE_ARITH, SEL_ADD, 1'b1, 1'b1, 32'hABCD_1234, 32'h1111_FFFF, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
